// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and memory-side handshake signals of the load/store sequencer.
// slave = sequencer view, master = pipeline/memory environment view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [1:0]        dsize;
  logic              zext;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              addr_err;
  logic              bus_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_rdy;

  modport slave (
    input  req, we, addr, wdata, dsize, zext, mem_rdata, mem_rdy,
    output busy, done, rdata, addr_err, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, dsize, zext, mem_rdata, mem_rdy,
    input  busy, done, rdata, addr_err, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-wide memory without byte enables (sub-word stores use RMW).
// Optional MEM_TIMEOUT_EN: per-phase wait-state limit that aborts the access with bus_err.
module mem_access_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_ERR, S_DONE} state_t;

  state_t            state, state_nx;
  logic              we_q, zext_q, berr_q;
  logic [1:0]        dsize_q, off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       merged_q, rdata_q;
  logic              misalign, timeout;

  // Big-endian lanes: offset 0 is bits 31:24.
  function automatic logic [31:0] lane_load(input logic [31:0] w, input logic [1:0] dsz,
                                            input logic [1:0] off, input logic zx);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[15:0] : w[31:16];
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    if (dsz == 2'd1) return {{16{h[15] & ~zx}}, h};
    if (dsz == 2'd2) return {{24{b[7] & ~zx}}, b};
    return w;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                             input logic [1:0] dsz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (dsz == 2'd1) begin
      if (off[1]) r[15:0] = d;
      else        r[31:16] = d;
    end else begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end
    return r;
  endfunction

  assign misalign = (bus.dsize == 2'd3) ||
                    (bus.dsize == 2'd1 && bus.addr[0]) ||
                    (bus.dsize == 2'd0 && bus.addr[1:0] != 2'd0);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt;

  // Counter restarts on every state change, so each RD/WR phase gets its own budget.
  always_ff @(posedge clk) begin
    if (rst || state != state_nx)                                 cnt <= '0;
    else if (!bus.mem_rdy && (state == S_RD || state == S_WR))    cnt <= cnt + 1'b1;
  end

  assign timeout = (state == S_RD || state == S_WR) && !bus.mem_rdy &&
                   cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.req) begin
        if (misalign)                          state_nx = S_ERR;
        else if (bus.we && bus.dsize == 2'd0)  state_nx = S_WR;
        else                                   state_nx = S_RD;
      end
      S_RD:   if (bus.mem_rdy)                 state_nx = we_q ? S_WR : S_DONE;
              else if (timeout)                state_nx = S_DONE;
      S_WR:   if (bus.mem_rdy || timeout)      state_nx = S_DONE;
      S_ERR:                                   state_nx = S_IDLE;
      S_DONE:                                  state_nx = S_IDLE;
      default:                                 state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      berr_q   <= 1'b0;
      dsize_q  <= '0;
      off_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.req) begin
          we_q     <= bus.we;
          zext_q   <= bus.zext;
          dsize_q  <= bus.dsize;
          off_q    <= bus.addr[1:0];
          waddr_q  <= bus.addr[ADDR_W+1:2];
          wdata_q  <= bus.wdata[15:0];
          merged_q <= bus.wdata;
          berr_q   <= 1'b0;
        end
        S_RD: if (bus.mem_rdy) begin
          if (we_q) merged_q <= lane_merge(bus.mem_rdata, wdata_q, dsize_q, off_q);
          else      rdata_q  <= lane_load(bus.mem_rdata, dsize_q, off_q, zext_q);
        end else if (timeout) begin
          berr_q <= 1'b1;
        end
        S_WR: if (!bus.mem_rdy && timeout) berr_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE) || (state == S_ERR);
  assign bus.addr_err  = (state == S_ERR);
  assign bus.bus_err   = (state == S_DONE) && berr_q;
  assign bus.mem_en    = (state == S_RD) || (state == S_WR);
  assign bus.mem_we    = (state == S_WR);
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = merged_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases with literal expectations plus random traffic
// checked every cycle against a timeline model computed from access type and wait states.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 10;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1 << 20;
`endif

  logic clk, rst;
  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;
  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int waitq [$];
  int wl;
  bit ph;

  // Timeline model of the access in flight; k = edges since the request was sampled.
  int k, m_lat, m_wr_start;
  bit active, m_err, m_load, m_writes, m_abort;
  logic [31:0] m_old_rd, m_new_rd, m_wword, cur_rd;
  logic [ADDR_W-1:0] m_word;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz,
                                      input logic [1:0] off, input logic zx);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) return w;
    if (sz == 2'd1) begin
      sh = 16 - 8 * int'(off);
      v = (w >> sh) & 32'hFFFF;
      if (!zx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      sh = 24 - 8 * int'(off);
      v = (w >> sh) & 32'hFF;
      if (!zx && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    int sh;
    mask = (sz == 2'd1) ? 32'hFFFF : 32'hFF;
    sh = ((sz == 2'd1) ? 16 : 24) - 8 * int'(off);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Memory responder: pops one wait count per phase, data valid only with mem_rdy.
  initial begin
    wl = 0; ph = 0;
    bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.mem_en) begin
        ph = 0; bus.mem_rdy = 1'b0; bus.mem_rdata = $urandom;
      end else begin
        if (!ph) begin ph = 1; wl = (waitq.size() > 0) ? waitq.pop_front() : 0; end
        if (wl == 0) begin bus.mem_rdy = 1'b1; bus.mem_rdata = mem[bus.mem_addr]; end
        else begin bus.mem_rdy = 1'b0; bus.mem_rdata = $urandom; wl--; end
      end
      @(posedge clk);
      if (bus.mem_en && bus.mem_rdy) begin
        ph = 0;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_rd;
    if (active) begin
      e_rd = (m_load && !m_err && !m_abort && k >= m_lat) ? m_new_rd : m_old_rd;
      chk("busy",     32'(bus.busy),     32'(k >= 1 && k <= m_lat));
      chk("done",     32'(bus.done),     32'(k == m_lat));
      chk("addr_err", 32'(bus.addr_err), 32'(k == m_lat && m_err));
      chk("bus_err",  32'(bus.bus_err),  32'(k == m_lat && m_abort));
      chk("rdata",    bus.rdata,         e_rd);
      chk("mem_en",   32'(bus.mem_en),   32'(!m_err && k >= 1 && k < m_lat));
      chk("mem_we",   32'(bus.mem_we),   32'(m_writes && k >= m_wr_start && k < m_lat));
      if (bus.mem_en) chk("mem_addr",  32'(bus.mem_addr), 32'(m_word));
      if (bus.mem_we) chk("mem_wdata", bus.mem_wdata,     m_wword);
    end
  end

  // Called mid-cycle; the request is sampled at the next rising edge.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic zx, input int wrd, input int wwr,
                        input bit hold, output int done_k, output int en_cnt,
                        output logic ae, output logic be);
    int rd_len, wr_len;
    bit rd_ab, wr_ab;
    rd_ab  = wrd > TO - 1;
    wr_ab  = wwr > TO - 1;
    rd_len = (rd_ab ? TO - 1 : wrd) + 1;
    wr_len = (wr_ab ? TO - 1 : wwr) + 1;
    m_word = a[ADDR_W+1:2];
    m_err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0);
    m_load = !w;
    m_old_rd = cur_rd;
    m_writes = 0; m_abort = 0; m_wr_start = 1;
    if (m_err) m_lat = 1;
    else if (!w) begin
      m_lat = 1 + rd_len; m_abort = rd_ab; waitq.push_back(wrd);
    end else if (sz == 2'd0) begin
      m_lat = 1 + wr_len; m_abort = wr_ab; m_writes = 1; waitq.push_back(wwr);
    end else begin
      waitq.push_back(wrd);
      if (rd_ab) begin
        m_lat = 1 + rd_len; m_abort = 1;
      end else begin
        waitq.push_back(wwr);
        m_lat = 1 + rd_len + wr_len; m_abort = wr_ab; m_writes = 1; m_wr_start = 1 + rd_len;
      end
    end
    m_new_rd = ext(ref_mem[m_word], sz, a[1:0], zx);
    m_wword  = (sz == 2'd0) ? d : merge(ref_mem[m_word], d, sz, a[1:0]);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.dsize = sz; bus.zext = zx;
    k = 0; active = 1;
    done_k = -1; en_cnt = 0; ae = 1'b0; be = 1'b0;
    for (int c = 1; c <= m_lat + 1; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.req = 1'b0;
      k = c;
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.done && done_k < 0) begin done_k = c; ae = bus.addr_err; be = bus.bus_err; end
      #1;
    end
    active = 0;
    if (!m_err && !m_abort) begin
      if (m_load) cur_rd = m_new_rd;
      else if (m_writes) ref_mem[m_word] = m_wword;
    end
    chk("mem_word", mem[m_word], ref_mem[m_word]);
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] = v; ref_mem[idx] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk, ec, n, wrd, wwr, r;
    logic ae, be, w, zx;
    logic [1:0] sz;
    logic [31:0] a, d, held;

    active = 0; k = 0; cur_rd = '0;
    m_lat = 0; m_wr_start = 0; m_err = 0; m_load = 0; m_writes = 0; m_abort = 0;
    m_old_rd = '0; m_new_rd = '0; m_wword = '0; m_word = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) poke(i, $urandom);
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.dsize = '0; bus.zext = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),   32'd0);
    chk("rst_done",  32'(bus.done),   32'd0);
    chk("rst_rdata", bus.rdata,       32'd0);
    chk("rst_en",    32'(bus.mem_en), 32'd0);
    chk("rst_wdata", bus.mem_wdata,   32'd0);
    #1 rst = 1'b0;

    // Signed / unsigned byte load, zero wait
    poke(4, 32'h12F4_5678);
    access(0, 32'h11, 0, 2'd2, 0, 0, 0, 0, dk, ec, ae, be);
    chk("sbyte_done_cyc", dk, 2);
    chk("sbyte_rdata", bus.rdata, 32'hFFFF_FFF4);
    access(0, 32'h11, 0, 2'd2, 1, 0, 0, 0, dk, ec, ae, be);
    chk("ubyte_rdata", bus.rdata, 32'h0000_00F4);

    // Half load with 3 wait states
    poke(4, 32'h1234_8001);
    access(0, 32'h12, 0, 2'd1, 0, 3, 0, 0, dk, ec, ae, be);
    chk("half_done_cyc", dk, 5);
    chk("half_en_cycles", ec, 4);
    chk("half_rdata", bus.rdata, 32'hFFFF_8001);

    // Byte store RMW and word store
    poke(5, 32'hAABB_CCDD);
    access(1, 32'h16, 32'h55, 2'd2, 0, 0, 0, 0, dk, ec, ae, be);
    chk("rmw_done_cyc", dk, 3);
    chk("rmw_word", mem[5], 32'hAABB_55DD);
    access(1, 32'h24, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, dk, ec, ae, be);
    chk("wst_done_cyc", dk, 2);
    chk("wst_word", mem[9], 32'hDEAD_BEEF);

    // Misaligned and illegal size
    access(0, 32'h3, 0, 2'd1, 0, 0, 0, 0, dk, ec, ae, be);
    chk("mis_half_cyc", dk, 1); chk("mis_half_err", 32'(ae), 1); chk("mis_half_en", ec, 0);
    access(1, 32'h2, 0, 2'd0, 0, 0, 0, 0, dk, ec, ae, be);
    chk("mis_word_cyc", dk, 1); chk("mis_word_err", 32'(ae), 1); chk("mis_word_en", ec, 0);
    access(0, 32'h0, 0, 2'd3, 0, 0, 0, 0, dk, ec, ae, be);
    chk("ill_size_cyc", dk, 1); chk("ill_size_err", 32'(ae), 1);

    // req held through a load: second access follows directly after done
    access(0, 32'h14, 0, 2'd1, 1, 1, 0, 1, dk, ec, ae, be);
    chk("hold_first_cyc", dk, 3);
    access(0, 32'h16, 0, 2'd0 == 2'd0 ? 2'd1 : 2'd1, 1, 0, 0, 0, dk, ec, ae, be);
    chk("hold_second_cyc", dk, 2);

`ifdef MEM_TIMEOUT_EN
    held = bus.rdata;
    access(0, 32'h20, 0, 2'd2, 0, 100, 0, 0, dk, ec, ae, be);
    chk("to_done_cyc", dk, 5);
    chk("to_en_cycles", ec, 4);
    chk("to_bus_err", 32'(be), 1);
    chk("to_rdata_held", bus.rdata, held);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      w  = 1'($urandom_range(0, 1));
      zx = 1'($urandom_range(0, 1));
      a  = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      d  = $urandom;
      wrd = $urandom_range(0, 5);
      wwr = $urandom_range(0, 5);
      access(w, a, d, sz, zx, wrd, wwr, 1'($urandom_range(0, 1)), dk, ec, ae, be);
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 1'b0;
        n = $urandom_range(1, 3);
        repeat (n) @(negedge clk);
        #1;
      end
    end
    bus.req = 1'b0;
    @(negedge clk); #1;

    // Reset in the middle of the write phase of a half store
    poke(7, 32'h1122_3344);
    waitq.push_back(0); waitq.push_back(50);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h1C; bus.wdata = 32'hCAFE; bus.dsize = 2'd1;
    @(posedge clk); #1 bus.req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.mem_we && n < 20) begin @(negedge clk); n++; end
    chk("rst_reach_wr", 32'(bus.mem_we), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_en",    32'(bus.mem_en), 32'd0);
    chk("rst_wr_busy",  32'(bus.busy),   32'd0);
    chk("rst_wr_done",  32'(bus.done),   32'd0);
    chk("rst_wr_rdata", bus.rdata,       32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_nodone", 32'(bus.done), 32'd0);
    chk("rst_wr_mem",    mem[7],        32'h1122_3344);
    waitq.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
